// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, waits LATENCY cycles, then pulses Ready.
// Optional byte-lane store enables are compiled in with `define DMEM_BYTE_EN.
module dmem_responder #(
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Req,
    input  logic        WE,
    input  logic [31:0] Addr,
    input  logic [31:0] DataIn,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]  ByteEn,
`endif
    output logic        Ready,
    output logic [31:0] DataOut,
    output logic        Busy,
    output logic        AddrErr
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q;
    logic                   we_q;
    logic [ADDR_BITS+1:0]   addr_q;
    logic [31:0]            din_q;
    logic [3:0]             lane_en;
    logic                   accept;
    logic                   access;
    logic                   misaligned;
    logic [ADDR_BITS-1:0]   idx;
    logic [31:0]            rd_word;
    logic [31:0]            merged;
    logic                   mem_we;
    logic [31:0]            mem [DEPTH];

    // Upper address bits alias by design; they are intentionally dropped.
    logic                   addr_hi_unused;
    assign addr_hi_unused = ^Addr[31:ADDR_BITS+2];

`ifdef DMEM_BYTE_EN
    logic [3:0] be_q;
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)      be_q <= 4'h0;
        else if (accept) be_q <= ByteEn;
    end
    assign lane_en = be_q;
`else
    assign lane_en = 4'hF;
`endif

    assign idx        = addr_q[ADDR_BITS+1:2];
    assign misaligned = |addr_q[1:0];
    assign rd_word    = mem[idx];
    assign mem_we     = access && we_q && !misaligned;
    assign Ready      = (state_q == S_RESP);
    assign Busy       = (state_q != S_IDLE);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            S_IDLE: if (Req) begin
                accept  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: if (cnt_q == 4'd0) begin
                access  = 1'b1;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        merged = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (lane_en[b]) merged[8*b +: 8] = din_q[8*b +: 8];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= 32'h0;
            DataOut <= 32'h0;
            AddrErr <= 1'b0;
        end else if (accept) begin
            cnt_q  <= 4'(LATENCY);
            we_q   <= WE;
            addr_q <= Addr[ADDR_BITS+1:0];
            din_q  <= DataIn;
        end else if (access) begin
            AddrErr <= misaligned;
            if (misaligned) DataOut <= 32'h0;
            else if (we_q)  DataOut <= merged;
            else            DataOut <= rd_word;
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // NOTE: the array is deliberately not reset; contents survive Rst_n like a real RAM.
    always_ff @(posedge Clk) begin
        if (mem_we) mem[idx] <= merged;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2 main instance, LATENCY=0 second instance).
module tb_dmem_responder;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        req, req0, we;
    logic [31:0] addr, din;
    logic [3:0]  be;
    logic        ready, busy, addr_err;
    logic [31:0] dout;
    logic        ready0, busy0, addr_err0;
    logic [31:0] dout0;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    dmem_responder #(.ADDR_BITS(6), .LATENCY(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req(req), .WE(we), .Addr(addr), .DataIn(din),
`ifdef DMEM_BYTE_EN
        .ByteEn(be),
`endif
        .Ready(ready), .DataOut(dout), .Busy(busy), .AddrErr(addr_err)
    );

    dmem_responder #(.ADDR_BITS(6), .LATENCY(0)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Req(req0), .WE(we), .Addr(addr), .DataIn(din),
`ifdef DMEM_BYTE_EN
        .ByteEn(be),
`endif
        .Ready(ready0), .DataOut(dout0), .Busy(busy0), .AddrErr(addr_err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Issues one request from IDLE and waits (bounded) for its Ready pulse.
    task automatic access(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic rerr);
        int lat;
        we = w; addr = a; din = d; req = 1'b1;
        tick();
        req = 1'b0;
        lat = 0;
        while (!ready && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_ready_seen"}, 32'(ready), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'd3);
        rdata = dout;
        rerr  = addr_err;
        tick();
    endtask

    logic [31:0] rd;
    logic        er;
    int          nready;

    initial begin
        Rst_n = 1'b1; req = 1'b0; req0 = 1'b0; we = 1'b0;
        addr = 32'h0; din = 32'h0; be = 4'hF;
        #1 Rst_n = 1'b0;

        // Held reset with a pending request: nothing may be accepted.
        we = 1'b1; addr = 32'h0000_0010; din = 32'hDEAD_BEEF; req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_ready", 32'(ready), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_dout", dout, 32'h0);
        end
        check("rst_err", 32'(addr_err), 32'd0);

        // Release with Req already high: edge 0 accepts, Ready only after edge 3.
        Rst_n = 1'b1;
        tick();
        req = 1'b0;
        check("e0_busy", 32'(busy), 32'd1);
        check("e0_ready", 32'(ready), 32'd0);
        tick();
        check("e1_ready", 32'(ready), 32'd0);
        tick();
        check("e2_ready", 32'(ready), 32'd0);
        check("e2_busy", 32'(busy), 32'd1);
        tick();
        check("e3_ready", 32'(ready), 32'd1);
        check("e3_dout", dout, 32'hDEAD_BEEF);
        check("e3_err", 32'(addr_err), 32'd0);
        tick();
        check("e4_ready", 32'(ready), 32'd0);
        check("e4_busy", 32'(busy), 32'd0);
        check("e4_dout_held", dout, 32'hDEAD_BEEF);

        access("ld10", 1'b0, 32'h0000_0010, 32'h0, rd, er);
        check("ld10_data", rd, 32'hDEAD_BEEF);
        check("ld10_err", 32'(er), 32'd0);

        // Aliasing modulo 256 bytes.
        access("st104", 1'b1, 32'h0000_0104, 32'h1234_5678, rd, er);
        check("st104_echo", rd, 32'h1234_5678);
        access("ld04", 1'b0, 32'h0000_0004, 32'h0, rd, er);
        check("ld04_alias", rd, 32'h1234_5678);
        access("ldhi", 1'b0, 32'hFFFF_FF04, 32'h0, rd, er);
        check("ldhi_alias", rd, 32'h1234_5678);

        // Misaligned store must not write and must flag the error.
        access("st20", 1'b1, 32'h0000_0020, 32'hCAFE_F00D, rd, er);
        access("st22", 1'b1, 32'h0000_0022, 32'h5555_5555, rd, er);
        check("st22_err", 32'(er), 32'd1);
        check("st22_dout", rd, 32'h0);
        access("ld20", 1'b0, 32'h0000_0020, 32'h0, rd, er);
        check("ld20_data", rd, 32'hCAFE_F00D);
        check("ld20_err", 32'(er), 32'd0);
        access("ld23", 1'b0, 32'h0000_0023, 32'h0, rd, er);
        check("ld23_err", 32'(er), 32'd1);
        check("ld23_dout", rd, 32'h0);

        // Req pulses during WAIT and RESP are ignored: exactly one Ready.
        we = 1'b0; addr = 32'h0000_0010; req = 1'b1;
        tick();
        nready = 0;
        for (int i = 0; i < 8; i++) begin
            req = (i >= 1 && i <= 3);
            tick();
            if (ready) begin
                nready++;
                check("busy_ld_dout", dout, 32'hDEAD_BEEF);
            end
        end
        check("busy_ld_nready", 32'(nready), 32'd1);
        check("busy_ld_idle", 32'(busy), 32'd0);

        // Reset during WAIT of a store discards it.
        access("st08_old", 1'b1, 32'h0000_0008, 32'h0BAD_F00D, rd, er);
        we = 1'b1; addr = 32'h0000_0008; din = 32'h7777_7777; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        Rst_n = 1'b0;
        #2;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_dout", dout, 32'h0);
        tick();
        Rst_n = 1'b1;
        nready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ready) nready++;
        end
        check("midrst_no_resp", 32'(nready), 32'd0);
        access("ld08", 1'b0, 32'h0000_0008, 32'h0, rd, er);
        check("ld08_old", rd, 32'h0BAD_F00D);

        // LATENCY=0 instance: Ready exactly one cycle after acceptance.
        we = 1'b1; addr = 32'h0000_0040; din = 32'h600D_CAFE; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        check("l0_busy", 32'(busy0), 32'd1);
        check("l0_ready_early", 32'(ready0), 32'd0);
        tick();
        check("l0_ready", 32'(ready0), 32'd1);
        check("l0_dout", dout0, 32'h600D_CAFE);
        check("l0_err", 32'(addr_err0), 32'd0);
        tick();
        check("l0_ready_off", 32'(ready0), 32'd0);
        check("l0_idle", 32'(busy0), 32'd0);

`ifdef DMEM_BYTE_EN
        be = 4'hF;
        access("be_full", 1'b1, 32'h0000_0030, 32'h1111_1111, rd, er);
        be = 4'b0101;
        access("be_part", 1'b1, 32'h0000_0030, 32'hAABB_CCDD, rd, er);
        check("be_part_echo", rd, 32'h11BB_11DD);
        be = 4'b0000;
        access("be_none", 1'b1, 32'h0000_0030, 32'hFFFF_FFFF, rd, er);
        check("be_none_echo", rd, 32'h11BB_11DD);
        be = 4'b0000;
        access("be_ld", 1'b0, 32'h0000_0030, 32'h0, rd, er);
        check("be_ld_data", rd, 32'h11BB_11DD);
        be = 4'hF;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
